// File: rtl/perips_pkg.sv
// Shared peripheral package: address map, bus payload and int_ctrl FSM states.
// No ports; imported by the timer and int_ctrl blocks.
package perips_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned ID_W   = 5;

  // Timer register block
  localparam logic [ADDR_W-1:0] TIMER_BASE     = 32'hffff0000;
  localparam logic [ADDR_W-1:0] TIMER_OFF_CTRL = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] TIMER_OFF_CMP  = 32'h0000_0004;
  localparam logic [ADDR_W-1:0] TIMER_OFF_CNT  = 32'h0000_0008;

  // Interrupt controller register block
  localparam logic [ADDR_W-1:0] INT_CTRL_BASE   = 32'hffff0040;
  localparam logic [ADDR_W-1:0] IC_OFF_PEND     = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] IC_OFF_ENAB     = 32'h0000_0004;
  localparam logic [ADDR_W-1:0] IC_OFF_TRIG     = 32'h0000_0008;
  localparam logic [ADDR_W-1:0] IC_OFF_CLAIM    = 32'h0000_000c;
  localparam logic [ADDR_W-1:0] IC_OFF_COMPLETE = 32'h0000_0010;

  typedef enum logic [1:0] {
    IC_IDLE = 2'd0,
    IC_REQ  = 2'd1,
    IC_SVC  = 2'd2
  } ic_st_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } bus_req_t;

  function automatic logic [ADDR_W-1:0] reg_addr(input logic [ADDR_W-1:0] base,
                                                 input logic [ADDR_W-1:0] off);
    return base | off;
  endfunction

endpackage

// File: rtl/int_ctrl_prio_enc.sv
// Lowest-index-first priority encoder.
// vec_i : request vector, id_c : index+1 of lowest set bit, 0 when none.
module prio_enc
  import perips_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]    vec_i,
  output logic [ID_W-1:0] id_c
);

  // Scan high to low so the lowest set index is the last to assign.
  always_comb begin
    id_c = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (vec_i[i]) id_c = ID_W'(i + 1);
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Memory-mapped interrupt controller with claim/complete handshake.
// clk, rst (async active-low) : clock and reset
// mem_we, mem_addr, mem_data  : shared bus; mem_data driven only on reads
// src_irq                     : peripheral requests, bit 0 = timer
// ext_int, ext_id             : registered request and winning ID to the core
module int_ctrl
  import perips_pkg::*;
#(
  parameter int unsigned       NUM_SRC = 8,
  parameter logic [ADDR_W-1:0] BASE    = INT_CTRL_BASE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_we,
  input  logic [ADDR_W-1:0]  mem_addr,
  inout  wire  [DATA_W-1:0]  mem_data,
  input  logic [NUM_SRC-1:0] src_irq,
  output logic               ext_int,
  output logic [ID_W-1:0]    ext_id
);

  localparam logic [ADDR_W-1:0] A_PEND     = reg_addr(BASE, IC_OFF_PEND);
  localparam logic [ADDR_W-1:0] A_ENAB     = reg_addr(BASE, IC_OFF_ENAB);
  localparam logic [ADDR_W-1:0] A_TRIG     = reg_addr(BASE, IC_OFF_TRIG);
  localparam logic [ADDR_W-1:0] A_CLAIM    = reg_addr(BASE, IC_OFF_CLAIM);
  localparam logic [ADDR_W-1:0] A_COMPLETE = reg_addr(BASE, IC_OFF_COMPLETE);

  ic_st_e             st_q, st_d;
  logic [NUM_SRC-1:0] enab_q, enab_d;
  logic [NUM_SRC-1:0] trig_q, trig_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] src_q, src_d;
  logic [NUM_SRC-1:0] insvc_q, insvc_d;
  logic               ext_int_q, ext_int_d;
  logic [ID_W-1:0]    ext_id_q, ext_id_d;

  bus_req_t           bus_c;
  logic [NUM_SRC-1:0] wsrc_c;
  logic               wr_enab_c, wr_trig_c, wr_claim_c, wr_complete_c;
  logic               claim_hit_c, complete_hit_c;
  logic               do_claim_c, do_complete_c;
  logic [NUM_SRC-1:0] cand_c, id_onehot_c, claim_clr_c, rise_c;
  logic [ID_W-1:0]    best_c;
  logic [DATA_W-1:0]  rdata_c;

  assign bus_c = '{we: mem_we, addr: mem_addr, data: mem_data};
  assign wsrc_c = bus_c.data[NUM_SRC-1:0];

  // Write decode
  assign wr_enab_c     = bus_c.we && (bus_c.addr == A_ENAB);
  assign wr_trig_c     = bus_c.we && (bus_c.addr == A_TRIG);
  assign wr_claim_c    = bus_c.we && (bus_c.addr == A_CLAIM);
  assign wr_complete_c = bus_c.we && (bus_c.addr == A_COMPLETE);

  // ext_id_q holds the requested ID in REQ and the claimed ID in SVC
  assign claim_hit_c    = wr_claim_c && (bus_c.data == DATA_W'(ext_id_q)) && (ext_id_q != '0);
  assign complete_hit_c = wr_complete_c && (bus_c.data == DATA_W'(ext_id_q)) && (ext_id_q != '0);

  assign cand_c = pend_q & enab_q & ~insvc_q;

  prio_enc #(.N(NUM_SRC)) u_prio_enc (
    .vec_i (cand_c),
    .id_c  (best_c)
  );

  // One-hot form of the current ext_id
  always_comb begin
    id_onehot_c = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      id_onehot_c[i] = (ext_id_q == ID_W'(i + 1));
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st_q <= IC_IDLE;
    else      st_q <= st_d;
  end

  // FSM next state
  always_comb begin
    st_d = st_q;
    case (st_q)
      IC_IDLE: if (best_c != '0) st_d = IC_REQ;
      IC_REQ: begin
        if (best_c == '0)     st_d = IC_IDLE;
        else if (claim_hit_c) st_d = IC_SVC;
      end
      IC_SVC:  if (complete_hit_c) st_d = IC_IDLE;
      default: st_d = IC_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    ext_int_d     = ext_int_q;
    ext_id_d      = ext_id_q;
    do_claim_c    = 1'b0;
    do_complete_c = 1'b0;
    case (st_q)
      IC_IDLE: begin
        ext_int_d = (best_c != '0);
        ext_id_d  = best_c;
      end
      IC_REQ: begin
        ext_id_d = best_c;
        if (best_c == '0) begin
          ext_int_d = 1'b0;
        end else if (claim_hit_c) begin
          ext_int_d  = 1'b0;
          ext_id_d   = ext_id_q;
          do_claim_c = 1'b1;
        end
      end
      IC_SVC: begin
        ext_int_d = 1'b0;
        if (complete_hit_c) begin
          do_complete_c = 1'b1;
          ext_id_d      = '0;
        end
      end
      default: begin
        ext_int_d = 1'b0;
        ext_id_d  = '0;
      end
    endcase
  end

  // Register file, pending latch and in-service tracking
  always_comb begin
    src_d  = src_irq;
    enab_d = wr_enab_c ? wsrc_c : enab_q;
    trig_d = wr_trig_c ? wsrc_c : trig_q;
    rise_c = src_irq & ~src_q;
    claim_clr_c = do_claim_c ? (id_onehot_c & trig_q) : '0;
    // Edge set takes precedence over a simultaneous claim clear
    pend_d = (src_irq & ~trig_q) | (trig_q & (rise_c | (pend_q & ~claim_clr_c)));
    insvc_d = insvc_q;
    if (do_claim_c)         insvc_d = id_onehot_c;
    else if (do_complete_c) insvc_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enab_q    <= '0;
      trig_q    <= '0;
      pend_q    <= '0;
      src_q     <= '0;
      insvc_q   <= '0;
      ext_int_q <= 1'b0;
      ext_id_q  <= '0;
    end else begin
      enab_q    <= enab_d;
      trig_q    <= trig_d;
      pend_q    <= pend_d;
      src_q     <= src_d;
      insvc_q   <= insvc_d;
      ext_int_q <= ext_int_d;
      ext_id_q  <= ext_id_d;
    end
  end

  // Combinational read mux; unmapped and COMPLETE read as 0
  always_comb begin
    rdata_c = '0;
    case (bus_c.addr)
      A_PEND:  rdata_c = DATA_W'(pend_q);
      A_ENAB:  rdata_c = DATA_W'(enab_q);
      A_TRIG:  rdata_c = DATA_W'(trig_q);
      A_CLAIM: rdata_c = DATA_W'(best_c);
      default: rdata_c = '0;
    endcase
  end

  assign mem_data = bus_c.we ? {DATA_W{1'bz}} : rdata_c;

  assign ext_int = ext_int_q;
  assign ext_id  = ext_id_q;

endmodule

// File: tb/tb_int_ctrl.sv
module tb_int_ctrl;

  localparam logic [31:0] BASE = 32'hffff0040;
  localparam logic [31:0] P = 32'h00, E = 32'h04, T = 32'h08, C = 32'h0c, M = 32'h10;

  logic        clk = 1'b0;
  logic        rst;
  logic        tb_we;
  logic [31:0] tb_addr;
  logic [31:0] tb_wdata;
  logic [7:0]  src;
  logic        ext_int;
  logic [4:0]  ext_id;
  wire  [31:0] mem_data;

  int checks = 0;
  int errors = 0;

  assign mem_data = tb_we ? tb_wdata : 32'bz;

  always #5 clk = ~clk;

  int_ctrl #(.NUM_SRC(8), .BASE(BASE)) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_we   (tb_we),
    .mem_addr (tb_addr),
    .mem_data (mem_data),
    .src_irq  (src),
    .ext_int  (ext_int),
    .ext_id   (ext_id)
  );

  // Behavioural model: sources, masks and one service slot
  typedef struct {
    logic [7:0] enab, trig, pend, srcq;
    int         claimed;   // 0 = nothing in service
    bit         irq;
    int         id;
  } model_t;

  model_t m;

  function automatic int best_of(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i + 1;
    return 0;
  endfunction

  function automatic logic [7:0] svc_mask(input model_t s);
    return (s.claimed != 0) ? (8'd1 << (s.claimed - 1)) : 8'd0;
  endfunction

  function automatic logic [31:0] model_rd(input model_t s, input logic [31:0] a);
    if (a == (BASE | P)) return {24'd0, s.pend};
    if (a == (BASE | E)) return {24'd0, s.enab};
    if (a == (BASE | T)) return {24'd0, s.trig};
    if (a == (BASE | C)) return 32'(best_of(s.pend & s.enab & ~svc_mask(s)));
    return 32'd0;
  endfunction

  function automatic model_t step(input model_t s, input bit we, input logic [31:0] a,
                                  input logic [31:0] d, input logic [7:0] sv);
    model_t n = s;
    logic [7:0] clr = 8'd0;
    int b = best_of(s.pend & s.enab & ~svc_mask(s));
    if (s.claimed != 0) begin
      if (we && a == (BASE | M) && d == 32'(s.claimed)) begin
        n.claimed = 0;
        n.id = 0;
      end
    end else if (!s.irq) begin
      n.irq = (b != 0);
      n.id  = b;
    end else if (b == 0) begin
      n.irq = 1'b0;
      n.id  = 0;
    end else if (we && a == (BASE | C) && d == 32'(s.id)) begin
      n.claimed = s.id;
      n.irq = 1'b0;
      clr = 8'd1 << (s.id - 1);
    end else begin
      n.id = b;
    end
    n.pend = (sv & ~s.trig) | (s.trig & ((sv & ~s.srcq) | (s.pend & ~clr)));
    n.srcq = sv;
    if (we && a == (BASE | E)) n.enab = d[7:0];
    if (we && a == (BASE | T)) n.trig = d[7:0];
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m <= '{enab: 8'd0, trig: 8'd0, pend: 8'd0, srcq: 8'd0, claimed: 0, irq: 1'b0, id: 0};
    else      m <= step(m, tb_we, tb_addr, tb_wdata, src);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One directed bus cycle: read data checked before the edge, outputs after it
  typedef struct {
    bit          we;
    logic [31:0] off;
    logic [31:0] data;     // write data, or expected read data
    logic [7:0]  src;
    bit          exp_int;
    bit          chk_id;
    logic [4:0]  exp_id;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input bit we, input logic [31:0] off, input logic [31:0] data,
                              input logic [7:0] sv, input bit ei, input bit ci, input logic [4:0] eid);
    vec_t v;
    v.we = we; v.off = off; v.data = data; v.src = sv;
    v.exp_int = ei; v.chk_id = ci; v.exp_id = eid;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; tb_we = 1'b0; tb_addr = BASE | 32'h20; tb_wdata = 32'd0; src = 8'd0;
    #1;
    check("reset_ext_int", 32'(ext_int), 32'd0);
    check("reset_ext_id", 32'(ext_id), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // Timer path
    vecs.push_back(mk(1, E, 32'h1,  8'h00, 0, 1, 0));
    vecs.push_back(mk(1, T, 32'h1,  8'h00, 0, 1, 0));
    vecs.push_back(mk(0, P, 32'h0,  8'h01, 0, 1, 0));
    vecs.push_back(mk(0, P, 32'h1,  8'h00, 1, 1, 1));
    vecs.push_back(mk(0, C, 32'h1,  8'h00, 1, 1, 1));
    vecs.push_back(mk(1, C, 32'h1,  8'h00, 0, 0, 0));
    vecs.push_back(mk(0, P, 32'h0,  8'h00, 0, 0, 0));
    vecs.push_back(mk(1, M, 32'h1,  8'h00, 0, 1, 0));
    vecs.push_back(mk(0, P, 32'h0,  8'h00, 0, 1, 0));
    vecs.push_back(mk(0, C, 32'h0,  8'h00, 0, 1, 0));
    vecs.push_back(mk(0, M, 32'h0,  8'h00, 0, 1, 0));
    // Priority (level mode); upper TRIG bits must be dropped
    vecs.push_back(mk(1, T, 32'hffffff00, 8'h00, 0, 1, 0));
    vecs.push_back(mk(0, T, 32'h0,  8'h00, 0, 1, 0));
    vecs.push_back(mk(1, E, 32'hff, 8'h00, 0, 1, 0));
    vecs.push_back(mk(0, P, 32'h0,  8'h24, 0, 1, 0));
    vecs.push_back(mk(0, P, 32'h24, 8'h24, 1, 1, 3));
    vecs.push_back(mk(1, C, 32'h3,  8'h24, 0, 0, 0));
    vecs.push_back(mk(0, C, 32'h6,  8'h24, 0, 0, 0));
    vecs.push_back(mk(1, M, 32'h3,  8'h24, 0, 0, 0));
    vecs.push_back(mk(0, P, 32'h24, 8'h24, 1, 1, 3));
    vecs.push_back(mk(0, P, 32'h24, 8'h20, 1, 1, 3));
    vecs.push_back(mk(0, P, 32'h20, 8'h20, 1, 1, 6));
    vecs.push_back(mk(0, P, 32'h20, 8'h00, 1, 1, 6));
    vecs.push_back(mk(0, P, 32'h0,  8'h00, 0, 1, 0));
    // Masking; upper ENAB bits must be dropped
    vecs.push_back(mk(1, E, 32'hffffff00, 8'h10, 0, 1, 0));
    vecs.push_back(mk(0, E, 32'h0,  8'h10, 0, 1, 0));
    vecs.push_back(mk(0, P, 32'h10, 8'h10, 0, 1, 0));
    vecs.push_back(mk(1, E, 32'h10, 8'h10, 0, 1, 0));
    vecs.push_back(mk(0, E, 32'h10, 8'h10, 1, 1, 5));
    vecs.push_back(mk(0, P, 32'h10, 8'h00, 1, 1, 5));
    vecs.push_back(mk(0, P, 32'h0,  8'h00, 0, 1, 0));
    // Handshake errors
    vecs.push_back(mk(1, E, 32'h2,  8'h02, 0, 1, 0));
    vecs.push_back(mk(0, P, 32'h2,  8'h02, 1, 1, 2));
    vecs.push_back(mk(1, C, 32'h5,  8'h02, 1, 1, 2));
    vecs.push_back(mk(1, C, 32'h2,  8'h02, 0, 0, 0));
    vecs.push_back(mk(1, M, 32'h7,  8'h02, 0, 0, 0));
    vecs.push_back(mk(0, C, 32'h0,  8'h02, 0, 0, 0));
    vecs.push_back(mk(0, P, 32'h2,  8'h02, 0, 0, 0));
    vecs.push_back(mk(1, M, 32'h2,  8'h02, 0, 0, 0));
    vecs.push_back(mk(0, P, 32'h2,  8'h02, 1, 1, 2));
    vecs.push_back(mk(0, P, 32'h2,  8'h00, 1, 1, 2));
    vecs.push_back(mk(0, P, 32'h0,  8'h00, 0, 1, 0));
    // Edge arriving with the claim of the same source
    vecs.push_back(mk(1, T, 32'h1,  8'h00, 0, 1, 0));
    vecs.push_back(mk(1, E, 32'h1,  8'h00, 0, 1, 0));
    vecs.push_back(mk(0, P, 32'h0,  8'h01, 0, 1, 0));
    vecs.push_back(mk(0, P, 32'h1,  8'h00, 1, 1, 1));
    vecs.push_back(mk(1, C, 32'h1,  8'h01, 0, 0, 0));
    vecs.push_back(mk(0, P, 32'h1,  8'h00, 0, 0, 0));
    vecs.push_back(mk(1, M, 32'h1,  8'h00, 0, 0, 0));
    vecs.push_back(mk(0, P, 32'h1,  8'h00, 1, 1, 1));

    foreach (vecs[n]) begin
      @(negedge clk);
      tb_we = vecs[n].we; tb_addr = BASE | vecs[n].off; tb_wdata = vecs[n].data; src = vecs[n].src;
      #1;
      if (!vecs[n].we) check($sformatf("vec%0d_rd", n), mem_data, vecs[n].data);
      @(posedge clk); #1;
      check($sformatf("vec%0d_int", n), 32'(ext_int), 32'(vecs[n].exp_int));
      if (vecs[n].chk_id) check($sformatf("vec%0d_id", n), 32'(ext_id), 32'(vecs[n].exp_id));
    end

    // Reset in the middle of service
    @(negedge clk);
    tb_we = 1'b1; tb_addr = BASE | C; tb_wdata = 32'd1;
    @(posedge clk); #1;
    check("svc_ext_int", 32'(ext_int), 32'd0);
    @(negedge clk);
    tb_we = 1'b0; tb_addr = BASE | E;
    rst = 1'b0;
    #1;
    check("rst_ext_int", 32'(ext_int), 32'd0);
    check("rst_ext_id", 32'(ext_id), 32'd0);
    check("rst_enab", mem_data, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tb_addr = BASE | 32'(4 * k);
      #1;
      check($sformatf("post_rst_rd%0d", k), mem_data, 32'd0);
    end
    // IDLE after reset: level request raises two edges after enable
    @(negedge clk);
    tb_we = 1'b1; tb_addr = BASE | E; tb_wdata = 32'd1; src = 8'h01;
    @(posedge clk); #1;
    check("post_rst_int0", 32'(ext_int), 32'd0);
    @(negedge clk);
    tb_we = 1'b0; tb_addr = BASE | 32'h20;
    @(posedge clk); #1;
    check("post_rst_int1", 32'(ext_int), 32'd1);
    check("post_rst_id1", 32'(ext_id), 32'd1);

    // Randomized traffic against the model
    src = 8'd0;
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      int r;
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) src = src ^ (8'd1 << $urandom_range(0, 7));
      r = $urandom_range(0, 15);
      tb_we = 1'b1;
      case (r)
        0: begin tb_addr = BASE | E; tb_wdata = $urandom; end
        1: begin tb_addr = BASE | T; tb_wdata = $urandom; end
        2, 3, 4: begin
          tb_addr = BASE | C;
          tb_wdata = ($urandom_range(0, 3) != 0) ? 32'(m.id) : 32'($urandom_range(0, 9));
        end
        5, 6: begin
          tb_addr = BASE | M;
          tb_wdata = ($urandom_range(0, 3) != 0) ? 32'(m.claimed) : 32'($urandom_range(0, 9));
        end
        default: begin
          tb_we = 1'b0;
          tb_addr = BASE | (32'($urandom_range(0, 6)) << 2);
          if (tb_addr == (BASE | 32'h18)) tb_addr = BASE | 32'h20;
        end
      endcase
      #1;
      if (!tb_we) check("rnd_rd", mem_data, model_rd(m, tb_addr));
      @(posedge clk); #1;
      check("rnd_int", 32'(ext_int), 32'(m.irq));
      if (m.claimed == 0) check("rnd_id", 32'(ext_id), 32'(m.id));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Memory-mapped interrupt controller sitting directly downstream of the timer and the other peripherals on the embedded SoC bus. It collects up to `NUM_SRC` interrupt request lines (timer_int on source 0), latches them as level or edge events, and masks them per source. It arbitrates by fixed priority, with the lowest index winning, and drives a single registered interrupt line plus a source ID to the core. The core services an interrupt through a claim/complete handshake over the shared `mem_we`/`mem_addr`/`mem_data` bus.

## Interface
- `NUM_SRC`, 8: number of interrupt sources, 1..31.
- `BASE`, 32'hffff0040: register block base. Register addresses are `BASE | offset`.
- `clk` in 1: system clock, single domain.
- `rst` in 1: reset, asynchronous, active-low.
- `mem_we` in 1: bus write strobe. 1 = write; 0 = read of the addressed register.
- `mem_addr` in 32: bus address, full-word compare.
- `mem_data` inout 32: bus data.
  - Driven only when `!mem_we`; otherwise high-Z.
  - A read of an unmapped address drives 0.
- `src_irq` in NUM_SRC: peripheral interrupt requests. Bit 0 is timer_int. All sources are synchronous to `clk`.
- `ext_int` out 1: interrupt request to the core. Registered; resets to 0.
- `ext_id` out 5: ID of the winning source (index+1); 0 = none. Registered; resets to 0.

## Operation
- Registers (offset: access):
  - 0x00 PEND: RO. Pending bits.
  - 0x04 ENAB: RW. Per-source enable. Reset 0.
  - 0x08 TRIG: RW. Per-source mode, 1 = rising edge, 0 = level. Reset 0.
  - 0x0C CLAIM: read returns the current best ID, with no side effect. A write claims.
  - 0x10 COMPLETE: WO; reads as 0. A write completes.
  - Bits [31:NUM_SRC] read as 0; writes to them are ignored.
- Sampling: `src_q <= src_irq` every cycle.
  - Level source: `pend[i] <= src_irq[i]`.
  - Edge source: `pend[i]` sets when `src_irq[i] & ~src_q[i]` and stays set until cleared by a claim.
- Candidate set: `pend & ENAB & ~insvc`. Best ID = lowest set index + 1, or 0 if the set is empty.
- FSM `st`, reset to IDLE:
  - IDLE: if best != 0, go to REQ. On the same edge, `ext_int<=1` and `ext_id<=best`.
  - REQ: `ext_id` tracks best every cycle.
    - If best becomes 0 (level source dropped or disabled), `ext_int<=0` and go to IDLE.
    - A write to CLAIM with data == `ext_id` (nonzero):
      - sets `insvc[id-1]`;
      - clears `pend[id-1]` if that source is edge mode;
      - `ext_int<=0`; go to SVC.
    - A write to CLAIM with a mismatched ID is ignored.
  - SVC: `ext_int` is held at 0 and no new request is raised.
    - A write to COMPLETE with data == the claimed ID clears `insvc` and goes to IDLE.
    - A mismatched COMPLETE write is ignored.
- Only one source is in service at a time, so `insvc` is one-hot or zero.
- Simultaneous events on one edge:
  - A new rising edge on a source coinciding with the claim-clear of that source: the set wins and the pend bit stays 1.
  - An ENAB write coinciding with a new request: the arbitration uses the new ENAB value starting from the next edge.
- Reset mid-operation returns every register, `pend`, `src_q`, `insvc` and the FSM to 0/IDLE immediately. `ext_int` and `ext_id` drop asynchronously.

## Timing
- Request latency:
  - `src_irq[i]` high before edge k (enabled, state IDLE, no higher-priority source) sets `pend[i]` at edge k.
  - `ext_int`=1 and `ext_id`=i+1 follow after edge k+1.
- A CLAIM write in cycle c drops `ext_int` after edge c.
- A COMPLETE write in cycle c enters IDLE after edge c. A still-pending source re-raises `ext_int` after edge c+1.
- Reads are combinational in the same cycle and have no side effects.
- Register writes take effect at the following edge.

## Structure
- The register offsets, BASE default and FSM state encodings go in the shared perips package. Timer and int_ctrl address constants live side by side there.
- One sub-module, `prio_enc`: a combinational lowest-index-first encoder, NUM_SRC-bit vector in, 5-bit ID out (0 = none).

## Test plan
- Timer path:
  - Setup: ENAB=0x1, TRIG=0x1. Pulse `src_irq[0]` for 1 cycle at edge k.
  - Required: `ext_int`=1 and `ext_id`=1 at k+1. PEND reads 0x1.
  - Write CLAIM=1: `ext_int`=0 and PEND=0.
  - Write COMPLETE=1: FSM returns to IDLE and `ext_int` stays 0.
- Priority:
  - Setup: ENAB=0xFF. Hold `src_irq[5]` and `src_irq[2]` high (level).
  - Required: `ext_id`=3.
  - CLAIM 3 then COMPLETE 3 with both still high: `ext_id`=3 again two edges later.
  - Drop bit 2: `ext_id`=6.
- Masking:
  - `src_irq[4]` high with ENAB=0x0: `ext_int` stays 0 and PEND=0x10.
  - Write ENAB=0x10: `ext_int`=1 two edges after the write.
- Handshake errors:
  - In REQ with `ext_id`=2, write CLAIM=5: no effect, `ext_int` stays 1.
  - In SVC on ID 2, write COMPLETE=7: no effect; the FSM stays in SVC.
- Edge during service:
  - Claim source 1 (edge mode) while a second `src_irq[0]` edge arrives in the same cycle.
  - Required: PEND bit0 stays 1, and `ext_int` re-asserts one edge after COMPLETE.
- Reset:
  - Assert `rst`=0 mid-SVC.
  - Required: `ext_int`=0, `ext_id`=0 and ENAB=0 immediately.
  - After release, the FSM is in IDLE and reads of all registers return 0.
